uart_line_buffer: RTL and testbench
===================================

// Module: uart_line_buffer
// PURPOSE
//  Line-buffering stage between the uart_rx byte strobe and the uart_tx next/ready handshake.
//  Assembles received bytes into lines, applies backspace editing, and queues up to LINES
//  committed lines. Replays each queued line to the transmitter followed by an optional CR LF.
//  Parametrised successor of the fixed tokenizer stage: configurable line length, depth and EOL.
// PARAMETERS
//  LINE_LEN    64  max stored bytes per line (>=2)
//  LINES       4   committed-line queue depth (power of 2, >=2)
//  APPEND_CRLF 1   1: emit 0x0D,0x0A after each line; 0: emit stored bytes only
// PORTS
//  i_clk        in   1   single clock (shared with uart_rx/uart_tx divided clock)
//  i_rst        in   1   synchronous, active-high reset
//  i_en         in   1   global enable; 0 freezes all state
//  i_data       in   8   received byte, valid when i_ready=1
//  i_ready      in   1   one-cycle receive strobe from uart_rx
//  i_next       in   1   one-cycle pulse from uart_tx: current o_data consumed
//  o_data       out  8   byte presented to uart_tx
//  o_data_ready out  1   o_data valid
//  o_line_ready out  1   >=1 committed line queued or in transmission
//  o_overflow   out  1   one-cycle pulse: byte or line dropped
//  o_lines      out  clog2(LINES)+1  committed lines not yet fully sent
// BEHAVIOUR
//  Reset: all outputs 0, wr/rd line pointers 0, column 0, cr_seen 0, tx FSM IDLE.
//  i_en=0: i_ready and i_next are ignored; every register holds.
//  Write side (on i_ready & i_en):
//   - 0x08/0x7F: column-- if column>0, else no-op.
//   - 0x0D: commit. 0x0A: commit unless the previous accepted byte was 0x0D (CRLF = one EOL).
//   - Commit: store length=column in the slot, advance wr ptr, column=0. Empty lines commit (length 0).
//   - Other byte: store at [wr_slot][column], column++; if column==LINE_LEN, drop the byte and pulse o_overflow.
//   - Queue full (o_lines==LINES): printable bytes are dropped and a commit is discarded
//     (column=0); both pulse o_overflow. Backspace is still applied.
//  Queue: wr/rd pointers carry an extra wrap bit. full = MSBs differ and LSBs equal; empty = equal.
//   o_lines = wr - rd (modulo 2*LINES). o_line_ready = (o_lines!=0).
//   A commit and a line completion in the same cycle leave o_lines unchanged.
//  Tx FSM: IDLE -> SEND (len>0) | SEND_CR (len==0 & APPEND_CRLF) | DONE (otherwise);
//   SEND -> SEND_CR|DONE after byte len-1; SEND_CR -> SEND_LF -> DONE; DONE: rd++ -> IDLE.
//   The state advances only on the cycle with i_next & o_data_ready & i_en.
//  Handshake: o_data/o_data_ready are registered. The first byte of a line is valid 1 cycle after
//   IDLE sees a non-empty queue. After consume, the next byte is valid on the following cycle.
//   o_data is stable while o_data_ready=1. i_next while o_data_ready=0 is ignored.
//  Latency: commit at cycle N -> o_data_ready=1 at N+2 when the queue was empty and the FSM was idle.
//  A len==0 line with APPEND_CRLF=0 retires in DONE without asserting o_data_ready.
//  Mid-operation reset: the queue is flushed and any partial line is lost; o_data_ready drops the next cycle.
// STRUCTURE
//  Package uart_line_pkg: ASCII_CR/LF/BS/DEL localparams, tx_state_t enum
//   {IDLE,SEND,SEND_CR,SEND_LF,DONE}, and a ptr-width function.
//  Sub-module line_store: LINES*LINE_LEN x 8 single-write, single-read memory plus a
//   length array; registered read port.
//  Top level: write-side column/commit logic, queue pointers, tx FSM.
// TESTING
//  1 "AB\r" via i_ready; uart_tx model pulses i_next -> o_data 0x41,0x42,0x0D,0x0A; o_lines 1->0.
//  2 "AB\r\n" then "C\n" -> exactly two lines sent ("AB"+CRLF, "C"+CRLF); no empty line in between.
//  3 "AX",0x08,"B\r" -> "AB" CRLF; 0x08 at column 0 -> no change and no overflow.
//  4 LINE_LEN=4: "ABCDEF\r" -> o_overflow pulses twice; "ABCD" CRLF sent.
//  5 LINES=2 with i_next held 0: commit 3 lines -> third discarded with an o_overflow pulse, o_lines=2;
//    then drain -> 2 lines only.
//  6 i_rst asserted during SEND of a line -> next cycle o_data_ready=0, o_lines=0, no further output;
//    i_en=0 while bytes arrive -> none stored.

Source files
------------

// File: rtl/uart_line_pkg.sv
// Shared constants and types for the UART line buffer.
package uart_line_pkg;

    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    typedef enum logic [2:0] {IDLE, SEND, SEND_CR, SEND_LF, DONE} tx_state_t;

    // Queue pointer width: slot index plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/line_store.sv
// Line storage: byte array per slot plus a per-slot length, registered byte read port.
module line_store #(
    parameter int unsigned LINE_LEN = 64,
    parameter int unsigned LINES    = 4,
    localparam int unsigned SW = $clog2(LINES),
    localparam int unsigned IW = $clog2(LINE_LEN),
    localparam int unsigned LW = $clog2(LINE_LEN + 1)
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [SW-1:0] wr_slot_i,
    input  logic [IW-1:0] wr_col_i,
    input  logic [7:0]    wr_data_i,
    input  logic          len_we_i,
    input  logic [LW-1:0] wr_len_i,
    input  logic          rd_en_i,
    input  logic [SW-1:0] rd_slot_i,
    input  logic [IW-1:0] rd_col_i,
    output logic [7:0]    rd_data_o,
    output logic [LW-1:0] rd_len_o
);

    logic [7:0]    mem_q [LINES][LINE_LEN];
    logic [LW-1:0] len_q [LINES];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_slot_i][wr_col_i] <= wr_data_i;
        end
        if (len_we_i) begin
            len_q[wr_slot_i] <= wr_len_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_slot_i][rd_col_i];
        end
    end

    // Length is needed in the same cycle the tx FSM leaves IDLE.
    assign rd_len_o = len_q[rd_slot_i];

endmodule

// File: rtl/uart_line_buffer.sv
// Assembles received bytes into edited lines, queues them and replays each to the transmitter.
module uart_line_buffer
    import uart_line_pkg::*;
#(
    parameter int unsigned LINE_LEN    = 64,
    parameter int unsigned LINES       = 4,
    parameter int unsigned APPEND_CRLF = 1,
    localparam int unsigned PW = ptr_width(LINES)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic [7:0]    i_data,
    input  logic          i_ready,
    input  logic          i_next,
    output logic [7:0]    o_data,
    output logic          o_data_ready,
    output logic          o_line_ready,
    output logic          o_overflow,
    output logic [PW-1:0] o_lines
);

    localparam int unsigned SW = PW - 1;
    localparam int unsigned IW = $clog2(LINE_LEN);
    localparam int unsigned LW = $clog2(LINE_LEN + 1);

    logic [LW-1:0] col_q, col_d;
    logic          cr_seen_q, cr_seen_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic          mem_we, len_we, full, empty, is_eol;

    tx_state_t     state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [LW-1:0] len_q, len_d;
    logic          rdy_q, rdy_d, fire;
    logic [7:0]    rd_data;
    logic [LW-1:0] rd_len;

    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[SW-1:0] == rd_ptr_q[SW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    // A LF directly after CR belongs to the same end-of-line.
    assign is_eol = (i_data == ASCII_CR) || ((i_data == ASCII_LF) && !cr_seen_q);

    always_comb begin
        col_d     = col_q;
        cr_seen_d = cr_seen_q;
        wr_ptr_d  = wr_ptr_q;
        ovf_d     = 1'b0;
        mem_we    = 1'b0;
        len_we    = 1'b0;
        if (i_en && i_ready) begin
            cr_seen_d = (i_data == ASCII_CR);
            if ((i_data == ASCII_BS) || (i_data == ASCII_DEL)) begin
                if (col_q != '0) col_d = col_q - 1'b1;
            end else if (is_eol) begin
                col_d = '0;
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    len_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end else if (i_data != ASCII_LF) begin
                if (full || (col_q == LW'(LINE_LEN))) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    col_d  = col_q + 1'b1;
                end
            end
        end
    end

    assign fire = i_en && i_next && rdy_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        rdy_d    = rdy_q;
        rd_ptr_d = rd_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (i_en && !empty) begin
                    len_d = rd_len;
                    idx_d = '0;
                    if (rd_len != '0) begin
                        state_d = SEND;
                        rdy_d   = 1'b1;
                    end else if (APPEND_CRLF != 0) begin
                        state_d = SEND_CR;
                        rdy_d   = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SEND: begin
                if (fire) begin
                    if ((LW'(idx_q) + 1'b1) == len_q) begin
                        if (APPEND_CRLF != 0) begin
                            state_d = SEND_CR;
                        end else begin
                            state_d = DONE;
                            rdy_d   = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SEND_CR: if (fire) state_d = SEND_LF;
            SEND_LF: begin
                if (fire) begin
                    state_d = DONE;
                    rdy_d   = 1'b0;
                end
            end
            DONE: begin
                if (i_en) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q     <= '0;
            cr_seen_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            rdy_q     <= 1'b0;
        end else if (i_en) begin
            col_q     <= col_d;
            cr_seen_q <= cr_seen_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            rdy_q     <= rdy_d;
        end
    end

    line_store #(
        .LINE_LEN(LINE_LEN),
        .LINES   (LINES)
    ) u_store (
        .clk_i    (i_clk),
        .wr_en_i  (mem_we),
        .wr_slot_i(wr_ptr_q[SW-1:0]),
        .wr_col_i (col_q[IW-1:0]),
        .wr_data_i(i_data),
        .len_we_i (len_we),
        .wr_len_i (col_q),
        .rd_en_i  (i_en),
        .rd_slot_i(rd_ptr_q[SW-1:0]),
        .rd_col_i (idx_d),
        .rd_data_o(rd_data),
        .rd_len_o (rd_len)
    );

    always_comb begin
        o_data = 8'h00;
        unique case (state_q)
            SEND:    o_data = rd_data;
            SEND_CR: o_data = ASCII_CR;
            SEND_LF: o_data = ASCII_LF;
            default: o_data = 8'h00;
        endcase
    end

    assign o_data_ready = rdy_q;
    assign o_overflow   = ovf_q;
    assign o_lines      = wr_ptr_q - rd_ptr_q;
    assign o_line_ready = (o_lines != '0);

endmodule

// File: tb/tb_uart_line_buffer.sv
// Directed bench for uart_line_buffer with LINE_LEN=4, LINES=2, CR LF appended.
module tb_uart_line_buffer;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_en = 1'b1;
    logic [7:0] i_data = 8'h00;
    logic       i_ready = 1'b0;
    logic       i_next = 1'b0;
    logic [7:0] o_data;
    logic       o_data_ready, o_line_ready, o_overflow;
    logic [1:0] o_lines;

    int total = 0;
    int bad = 0;
    int ovf_cnt = 0;
    logic [7:0] rxq[$];
    logic [7:0] exp[$];

    always #5 clk = ~clk;

    always @(posedge clk) if (o_overflow) ovf_cnt <= ovf_cnt + 1;

    uart_line_buffer #(
        .LINE_LEN   (4),
        .LINES      (2),
        .APPEND_CRLF(1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_data      (i_data),
        .i_ready     (i_ready),
        .i_next      (i_next),
        .o_data      (o_data),
        .o_data_ready(o_data_ready),
        .o_line_ready(o_line_ready),
        .o_overflow  (o_overflow),
        .o_lines     (o_lines)
    );

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_data  = b;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // uart_tx model: consume every presented byte for a fixed number of cycles.
    task automatic drain(input int cycles);
        rxq.delete();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (o_data_ready) begin
                rxq.push_back(o_data);
                i_next = 1'b1;
            end else begin
                i_next = 1'b0;
            end
        end
        @(negedge clk);
        i_next = 1'b0;
    endtask

    task automatic wait_ready(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cycles && !ok; c++) begin
            @(negedge clk);
            ok = o_data_ready;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        total++;
        if ({o_data_ready, o_line_ready, o_overflow, o_lines, o_data} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b lr=%b ovf=%b lines=%0d data=%h want all 0",
                     o_data_ready, o_line_ready, o_overflow, o_lines, o_data);
        end
    endtask

    task automatic test_basic();
        send_str("AB\r");
        total++;
        if (o_lines !== 2'd1 || o_data_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_commit: got lines=%0d rdy=%b want lines=1 rdy=0",
                     o_lines, o_data_ready);
        end
        @(negedge clk);
        total++;
        if (o_data_ready !== 1'b1 || o_data !== 8'h41) begin
            bad++;
            $display("FAIL basic_latency: got rdy=%b data=%h want rdy=1 data=41",
                     o_data_ready, o_data);
        end
        drain(20);
        exp = '{8'h41, 8'h42, 8'h0D, 8'h0A};
        total++;
        if (rxq.size() != exp.size()) begin
            bad++;
            $display("FAIL basic_count: got %0d want %0d", rxq.size(), exp.size());
        end
        foreach (exp[i]) if (i < rxq.size()) begin
            total++;
            if (rxq[i] !== exp[i]) begin
                bad++;
                $display("FAIL basic_byte%0d: got %h want %h", i, rxq[i], exp[i]);
            end
        end
        total++;
        if (o_lines !== 2'd0 || o_line_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_retired: got lines=%0d lr=%b want 0 0", o_lines, o_line_ready);
        end
    endtask

    task automatic test_crlf_pair();
        int ovf0;
        ovf0 = ovf_cnt;
        send_str("AB\r\nC\n");
        total++;
        if (o_lines !== 2'd2) begin
            bad++;
            $display("FAIL crlf_lines: got %0d want 2", o_lines);
        end
        drain(40);
        exp = '{8'h41, 8'h42, 8'h0D, 8'h0A, 8'h43, 8'h0D, 8'h0A};
        total++;
        if (rxq.size() != exp.size()) begin
            bad++;
            $display("FAIL crlf_count: got %0d want %0d", rxq.size(), exp.size());
        end
        foreach (exp[i]) if (i < rxq.size()) begin
            total++;
            if (rxq[i] !== exp[i]) begin
                bad++;
                $display("FAIL crlf_byte%0d: got %h want %h", i, rxq[i], exp[i]);
            end
        end
        total++;
        if (ovf_cnt != ovf0) begin
            bad++;
            $display("FAIL crlf_no_ovf: got %0d pulses want 0", ovf_cnt - ovf0);
        end
    endtask

    task automatic test_backspace();
        int ovf0;
        ovf0 = ovf_cnt;
        send_byte(8'h08);
        total++;
        if (o_lines !== 2'd0) begin
            bad++;
            $display("FAIL bs_col0_lines: got %0d want 0", o_lines);
        end
        send_str("AX");
        send_byte(8'h08);
        send_str("B\r");
        drain(20);
        exp = '{8'h41, 8'h42, 8'h0D, 8'h0A};
        total++;
        if (rxq.size() != exp.size()) begin
            bad++;
            $display("FAIL bs_count: got %0d want %0d", rxq.size(), exp.size());
        end
        foreach (exp[i]) if (i < rxq.size()) begin
            total++;
            if (rxq[i] !== exp[i]) begin
                bad++;
                $display("FAIL bs_byte%0d: got %h want %h", i, rxq[i], exp[i]);
            end
        end
        total++;
        if (ovf_cnt != ovf0) begin
            bad++;
            $display("FAIL bs_no_ovf: got %0d pulses want 0", ovf_cnt - ovf0);
        end
    endtask

    task automatic test_empty_line();
        send_str("\r");
        drain(20);
        exp = '{8'h0D, 8'h0A};
        total++;
        if (rxq.size() != exp.size()) begin
            bad++;
            $display("FAIL empty_count: got %0d want %0d", rxq.size(), exp.size());
        end
        foreach (exp[i]) if (i < rxq.size()) begin
            total++;
            if (rxq[i] !== exp[i]) begin
                bad++;
                $display("FAIL empty_byte%0d: got %h want %h", i, rxq[i], exp[i]);
            end
        end
    endtask

    task automatic test_long_line();
        int ovf0;
        ovf0 = ovf_cnt;
        send_str("ABCDEF\r");
        drain(30);
        total++;
        if (ovf_cnt - ovf0 != 2) begin
            bad++;
            $display("FAIL long_ovf: got %0d pulses want 2", ovf_cnt - ovf0);
        end
        exp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        total++;
        if (rxq.size() != exp.size()) begin
            bad++;
            $display("FAIL long_count: got %0d want %0d", rxq.size(), exp.size());
        end
        foreach (exp[i]) if (i < rxq.size()) begin
            total++;
            if (rxq[i] !== exp[i]) begin
                bad++;
                $display("FAIL long_byte%0d: got %h want %h", i, rxq[i], exp[i]);
            end
        end
    endtask

    task automatic test_queue_full();
        int ovf0;
        ovf0 = ovf_cnt;
        send_str("A\rB\r\r");
        repeat (2) @(negedge clk);
        total++;
        if (o_lines !== 2'd2 || o_line_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_lines: got lines=%0d lr=%b want 2 1", o_lines, o_line_ready);
        end
        total++;
        if (ovf_cnt - ovf0 != 1) begin
            bad++;
            $display("FAIL full_ovf: got %0d pulses want 1", ovf_cnt - ovf0);
        end
        drain(40);
        exp = '{8'h41, 8'h0D, 8'h0A, 8'h42, 8'h0D, 8'h0A};
        total++;
        if (rxq.size() != exp.size()) begin
            bad++;
            $display("FAIL full_count: got %0d want %0d", rxq.size(), exp.size());
        end
        foreach (exp[i]) if (i < rxq.size()) begin
            total++;
            if (rxq[i] !== exp[i]) begin
                bad++;
                $display("FAIL full_byte%0d: got %h want %h", i, rxq[i], exp[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        send_str("AB\r");
        wait_ready(10, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rst_wait_ready: got rdy=0 want rdy=1 within 10 cycles");
        end
        i_next = 1'b1;
        @(negedge clk);
        i_next = 1'b0;
        total++;
        if (o_data !== 8'h42 || o_data_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_second_byte: got data=%h rdy=%b want 42 1", o_data, o_data_ready);
        end
        send_str("Z");
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        total++;
        if (o_data_ready !== 1'b0 || o_lines !== 2'd0 || o_line_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_flush: got rdy=%b lines=%0d lr=%b want 0 0 0",
                     o_data_ready, o_lines, o_line_ready);
        end
        drain(15);
        total++;
        if (rxq.size() != 0) begin
            bad++;
            $display("FAIL rst_no_output: got %0d bytes want 0", rxq.size());
        end
        // Partial "Z" must be gone: a bare CR now sends an empty line.
        send_str("\r");
        drain(20);
        total++;
        if (rxq.size() != 2 || rxq[0] !== 8'h0D || rxq[1] !== 8'h0A) begin
            bad++;
            $display("FAIL rst_partial_lost: got %0d bytes first=%h want 2 bytes 0D 0A",
                     rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
        end
    endtask

    task automatic test_enable();
        bit ok;
        i_en = 1'b0;
        send_str("XY\r");
        i_en = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (o_lines !== 2'd0 || o_data_ready !== 1'b0) begin
            bad++;
            $display("FAIL en_ignored: got lines=%0d rdy=%b want 0 0", o_lines, o_data_ready);
        end
        send_str("Q\r");
        wait_ready(10, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL en_wait_ready: got rdy=0 want rdy=1 within 10 cycles");
        end
        i_en = 1'b0;
        i_next = 1'b1;
        repeat (3) @(negedge clk);
        i_next = 1'b0;
        total++;
        if (o_data !== 8'h51 || o_data_ready !== 1'b1) begin
            bad++;
            $display("FAIL en_frozen: got data=%h rdy=%b want 51 1", o_data, o_data_ready);
        end
        i_en = 1'b1;
        drain(20);
        exp = '{8'h51, 8'h0D, 8'h0A};
        total++;
        if (rxq.size() != exp.size()) begin
            bad++;
            $display("FAIL en_count: got %0d want %0d", rxq.size(), exp.size());
        end
        foreach (exp[i]) if (i < rxq.size()) begin
            total++;
            if (rxq[i] !== exp[i]) begin
                bad++;
                $display("FAIL en_byte%0d: got %h want %h", i, rxq[i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crlf_pair();
        test_backspace();
        test_empty_line();
        test_long_line();
        test_queue_full();
        test_mid_reset();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
